// File: rtl/node_nic_pkg.sv
// ----------------------------------------------------------------------------
// node_nic_pkg
// Types shared by the node-side NIC and its packet FIFO.
//   pkt_t        32-bit packet: destID[31:28], sourceID[27:24], data[23:0]
//   PKT_BYTES    bytes per packet on the 8-bit link
//   nic_state_t  link FSM states (TX uses IDLE/SEND, RX uses IDLE/RECV)
//   pkt_byte()   selects link byte idx of a packet, byte 0 = bits [31:24]
// ----------------------------------------------------------------------------
package node_nic_pkg;

    localparam int PKT_BYTES = 4;

    // Byte 0 on the link carries destID in its high nibble and this node's
    // sourceID in its low nibble.
    typedef struct packed {
        logic [3:0]  destID;
        logic [3:0]  sourceID;
        logic [23:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2
    } nic_state_t;

    function automatic logic [7:0] pkt_byte(input pkt_t p, input logic [1:0] idx);
        logic [31:0] w;
        w = p;
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/node_nic_pkt_fifo.sv
// ----------------------------------------------------------------------------
// nic_pkt_fifo
// Synchronous pkt_t FIFO, DEPTH entries (power of 2, >= 2).
//   clk, rst_b         clock / asynchronous active-low reset
//   i_wr_en, i_wr_data write port; accepted when not full, or full with a pop
//   i_rd_en, o_rd_data read port; o_rd_data is the head, pop when not empty
//   o_full, o_empty    status
//   o_count            occupancy, $clog2(DEPTH)+1 bits
// ----------------------------------------------------------------------------
module nic_pkt_fifo
    import node_nic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     i_wr_en,
    input  pkt_t                     i_wr_data,
    input  logic                     i_rd_en,
    output pkt_t                     o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    pkt_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_rd;
    logic          w_do_wr;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_do_rd = i_rd_en && !o_empty;
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; empty/count are reset, so stale
    // contents are never observed and the array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/node_nic.sv
// ----------------------------------------------------------------------------
// node_nic
// Node-side NIC for one router port. TX queues packets from the node and
// serialises each as 4 bytes (MSB first) on put/payload_outbound when the
// router signals free_outbound. RX deserialises 4-byte bursts into a queue
// presented to the node with valid/ready.
//   clk, rst_b                         clock / async active-low reset
//   tx_valid, tx_pkt, tx_ready         node -> NIC packet handshake
//   rx_valid, rx_pkt, rx_ready         NIC -> node packet handshake
//   free_outbound, put_outbound,
//   payload_outbound                   outbound byte link to the router
//   free_inbound, put_inbound,
//   payload_inbound                    inbound byte link from the router
//   proto_err                          sticky inbound protocol error
// Build option: NIC_PROTO_CHECK_EN enables the proto_err checker; otherwise
// proto_err is tied low. Abort/ignore handling is identical either way.
// ----------------------------------------------------------------------------
module node_nic
    import node_nic_pkg::*;
#(
    parameter int NODEID  = 0,
    parameter int TXDEPTH = 4,
    parameter int RXDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        tx_valid,
    input  logic [31:0] tx_pkt,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [31:0] rx_pkt,
    input  logic        rx_ready,
    input  logic        free_outbound,
    output logic        put_outbound,
    output logic [7:0]  payload_outbound,
    output logic        free_inbound,
    input  logic        put_inbound,
    input  logic [7:0]  payload_inbound,
    output logic        proto_err
);

    localparam int TX_CW = $clog2(TXDEPTH) + 1;
    localparam int RX_CW = $clog2(RXDEPTH) + 1;

    // ---------------- TX path ----------------
    nic_state_t     r_tx_state, w_tx_state_next;
    logic [1:0]     r_tx_cnt;
    pkt_t           r_tx_pkt;
    logic           r_tx_ready;
    logic           r_put_out;
    logic [7:0]     r_payload_out;
    pkt_t           w_tx_in;
    pkt_t           w_tx_head;
    logic           w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [TX_CW-1:0] w_tx_count;
    logic [TX_CW:0]   w_tx_occ_next;

    always_comb begin
        w_tx_in          = pkt_t'(tx_pkt);
        w_tx_in.sourceID = 4'(NODEID);
    end

    assign w_tx_push = tx_valid && r_tx_ready && !w_tx_full;

    nic_pkt_fifo #(.DEPTH(TXDEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .i_wr_en   (w_tx_push),
        .i_wr_data (w_tx_in),
        .i_rd_en   (w_tx_pop),
        .o_rd_data (w_tx_head),
        .o_full    (w_tx_full),
        .o_empty   (w_tx_empty),
        .o_count   (w_tx_count)
    );

    // NOTE: combinational blocks assign every output a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_pop        = 1'b0;
        case (r_tx_state)
            IDLE: if (!w_tx_empty && free_outbound) begin
                w_tx_state_next = SEND;
                w_tx_pop        = 1'b1;
            end
            SEND: if (r_tx_cnt == 2'(PKT_BYTES - 1)) w_tx_state_next = IDLE;
            default: w_tx_state_next = IDLE;
        endcase
    end

    assign w_tx_occ_next = {1'b0, w_tx_count} + (TX_CW+1)'(w_tx_push) - (TX_CW+1)'(w_tx_pop);

    // Link outputs lag the SEND state by one register stage, which yields the
    // push-to-first-byte latency of two edges and the idle gap between bursts.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_tx_state    <= IDLE;
            r_tx_cnt      <= '0;
            r_tx_pkt      <= '0;
            r_tx_ready    <= 1'b0;
            r_put_out     <= 1'b0;
            r_payload_out <= '0;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_ready <= (w_tx_occ_next < (TX_CW+1)'(TXDEPTH));
            if (w_tx_pop) begin
                r_tx_pkt <= w_tx_head;
                r_tx_cnt <= '0;
            end else if (r_tx_state == SEND) begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
            r_put_out     <= (r_tx_state == SEND);
            r_payload_out <= (r_tx_state == SEND) ? pkt_byte(r_tx_pkt, r_tx_cnt) : 8'h00;
        end
    end

    assign tx_ready         = r_tx_ready;
    assign put_outbound     = r_put_out;
    assign payload_outbound = r_payload_out;

    // ---------------- RX path ----------------
    nic_state_t     r_rx_state, w_rx_state_next;
    logic [1:0]     r_rx_cnt;
    logic [31:0]    r_rx_shift;
    logic           r_rx_wr;
    logic           r_free_in;
    logic           w_rx_stage;
    logic           w_rx_pop, w_rx_full, w_rx_empty;
    pkt_t           w_rx_head;
    logic [RX_CW-1:0] w_rx_count;
    logic [RX_CW:0]   w_rx_occ_next;

    assign w_rx_pop = rx_ready && !w_rx_empty;

    nic_pkt_fifo #(.DEPTH(RXDEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .i_wr_en   (r_rx_wr && (!w_rx_full || w_rx_pop)),
        .i_wr_data (pkt_t'(r_rx_shift)),
        .i_rd_en   (w_rx_pop),
        .o_rd_data (w_rx_head),
        .o_full    (w_rx_full),
        .o_empty   (w_rx_empty),
        .o_count   (w_rx_count)
    );

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_stage      = 1'b0;
        case (r_rx_state)
            IDLE: if (put_inbound && r_free_in) w_rx_state_next = RECV;
            RECV: begin
                if (!put_inbound) begin
                    w_rx_state_next = IDLE;
                end else if (r_rx_cnt == 2'(PKT_BYTES - 1)) begin
                    w_rx_state_next = IDLE;
                    w_rx_stage      = 1'b1;
                end
            end
            default: w_rx_state_next = IDLE;
        endcase
    end

    // Occupancy counts the packet staged in r_rx_shift awaiting its queue
    // write, so free_inbound never advertises a slot that is already promised.
    assign w_rx_occ_next = {1'b0, w_rx_count} + (RX_CW+1)'(r_rx_wr)
                         + (RX_CW+1)'(w_rx_stage) - (RX_CW+1)'(w_rx_pop);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rx_state <= IDLE;
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            r_rx_wr    <= 1'b0;
            r_free_in  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_next;
            r_rx_wr    <= w_rx_stage;
            r_free_in  <= (w_rx_state_next == IDLE) && (w_rx_occ_next < (RX_CW+1)'(RXDEPTH));
            if (r_rx_state == IDLE && put_inbound && r_free_in) begin
                r_rx_shift <= {24'h0, payload_inbound};
                r_rx_cnt   <= 2'd1;
            end else if (r_rx_state == RECV && put_inbound) begin
                r_rx_shift <= {r_rx_shift[23:0], payload_inbound};
                r_rx_cnt   <= r_rx_cnt + 1'b1;
            end
        end
    end

    assign free_inbound = r_free_in;
    assign rx_valid     = !w_rx_empty;
    assign rx_pkt       = w_rx_empty ? 32'h0 : w_rx_head;

    // ---------------- Protocol checker ----------------
`ifdef NIC_PROTO_CHECK_EN
    logic r_proto_err;
    logic w_proto_viol;

    // (a) byte offered while not free in IDLE, (b) burst cut short in RECV.
    assign w_proto_viol = (r_rx_state == IDLE && put_inbound && !r_free_in)
                       || (r_rx_state == RECV && !put_inbound);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)            r_proto_err <= 1'b0;
        else if (w_proto_viol) r_proto_err <= 1'b1;
    end

    assign proto_err = r_proto_err;
`else
    assign proto_err = 1'b0;
`endif

endmodule
